// File: rtl/word_distributor_8x16.sv
// word_distributor_8x16: registered 1-to-8 word distributor with frame tracking.
// Accepts words on a valid/ready handshake and steers each one into a held bank.
// The bank is chosen by an explicit select or by an auto-incrementing pointer.
module word_distributor_8x16 #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN0,
  input  logic             A2,
  input  logic             A1,
  input  logic             A0,
  input  logic             AUTO,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             CLEAR,
  input  logic             OUT_ACK,
  output logic [WIDTH-1:0] OUT7,
  output logic [WIDTH-1:0] OUT6,
  output logic [WIDTH-1:0] OUT5,
  output logic [WIDTH-1:0] OUT4,
  output logic [WIDTH-1:0] OUT3,
  output logic [WIDTH-1:0] OUT2,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT0,
  output logic [7:0]       LOADED,
  output logic [2:0]       PTR,
  output logic             FRAME_DONE
);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bank_q [8];
  logic [7:0]       loaded_q, loaded_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             done_q, done_d;
  logic [2:0]       dest;
  logic             xfer;

  // Handshake decode and destination select
  always_comb begin
    IN_READY = RST_N & (state_q == FILL) & ~CLEAR;
    xfer     = IN_VALID & IN_READY;
    dest     = AUTO ? ptr_q : {A2, A1, A0};
  end

  // Next-state, frame tracking and pointer update; CLEAR outranks everything
  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    if (CLEAR) begin
      state_d  = FILL;
      loaded_d = '0;
      ptr_d    = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (xfer) begin
            loaded_d = loaded_q | (8'(1) << dest);
            if (AUTO) ptr_d = ptr_q + 3'd1;
            if (loaded_d == 8'hFF) begin
              state_d = FULL;
              done_d  = 1'b1;
            end
          end
        end
        FULL: begin
          if (OUT_ACK) begin
            state_d  = FILL;
            loaded_d = '0;
            ptr_d    = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= FILL;
      loaded_q <= '0;
      ptr_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
    end
  end

  // Output banks: written only on an accepted transfer, otherwise held
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 8; i++) bank_q[i] <= '0;
    end else if (xfer) begin
      bank_q[dest] <= IN0;
    end
  end

  // Port mapping
  always_comb begin
    OUT0       = bank_q[0];
    OUT1       = bank_q[1];
    OUT2       = bank_q[2];
    OUT3       = bank_q[3];
    OUT4       = bank_q[4];
    OUT5       = bank_q[5];
    OUT6       = bank_q[6];
    OUT7       = bank_q[7];
    LOADED     = loaded_q;
    PTR        = ptr_q;
    FRAME_DONE = done_q;
  end

endmodule

// File: tb/tb_word_distributor_8x16.sv
// tb_word_distributor_8x16: directed self-checking bench for word_distributor_8x16.
module tb_word_distributor_8x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in0;
  logic        a2, a1, a0;
  logic        auto_m;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic        out_ack;
  logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  loaded;
  logic [2:0]  ptr;
  logic        frame_done;
  logic [15:0] outs [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign outs[0] = o0;
  assign outs[1] = o1;
  assign outs[2] = o2;
  assign outs[3] = o3;
  assign outs[4] = o4;
  assign outs[5] = o5;
  assign outs[6] = o6;
  assign outs[7] = o7;

  word_distributor_8x16 #(.WIDTH(16)) dut (
    .CLK(clk), .RST_N(rst_n), .IN0(in0), .A2(a2), .A1(a1), .A0(a0),
    .AUTO(auto_m), .IN_VALID(in_valid), .IN_READY(in_ready), .CLEAR(clear),
    .OUT_ACK(out_ack), .OUT7(o7), .OUT6(o6), .OUT5(o5), .OUT4(o4),
    .OUT3(o3), .OUT2(o2), .OUT1(o1), .OUT0(o0), .LOADED(loaded), .PTR(ptr),
    .FRAME_DONE(frame_done)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_addr(input logic [2:0] a);
    {a2, a1, a0} = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in0 = '0; {a2, a1, a0} = '0; auto_m = 1'b0;
    in_valid = 1'b0; clear = 1'b0; out_ack = 1'b0;
    #12;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 16'h0) begin
        errors++; $display("FAIL reset_out%0d: got %h want 0000", i, outs[i]);
      end
    end
    checks++;
    if (loaded !== 8'h00 || ptr !== 3'd0 || frame_done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: loaded=%h ptr=%0d done=%b ready=%b want 00 0 0 0",
               loaded, ptr, frame_done, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_auto_fill();
    auto_m = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in0 = 16'h1000 + 16'(i);
      cycle();
      checks++;
      if (ptr !== 3'((i + 1) % 8)) begin
        errors++; $display("FAIL fill_ptr%0d: got %0d want %0d", i, ptr, (i + 1) % 8);
      end
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++; $display("FAIL fill_done%0d: got %b want %b", i, frame_done, i == 7);
      end
      checks++;
      if (in_ready !== (i != 7)) begin
        errors++; $display("FAIL fill_ready%0d: got %b want %b", i, in_ready, i != 7);
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL fill_done_once: got %b want 0", frame_done);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 16'h1000 + 16'(i)) begin
        errors++; $display("FAIL fill_out%0d: got %h want %h", i, outs[i], 16'h1000 + 16'(i));
      end
    end
    checks++;
    if (loaded !== 8'hFF) begin
      errors++; $display("FAIL fill_loaded: got %h want ff", loaded);
    end
  endtask

  task automatic test_full_hold();
    in0 = 16'hDEAD; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (loaded !== 8'hFF || in_ready !== 1'b0 || frame_done !== 1'b0 || ptr !== 3'd0) begin
        errors++;
        $display("FAIL full_hold%0d: loaded=%h ready=%b done=%b ptr=%0d want ff 0 0 0",
                 k, loaded, in_ready, frame_done, ptr);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 16'h1000 + 16'(i)) begin
        errors++; $display("FAIL full_out%0d: got %h want %h", i, outs[i], 16'h1000 + 16'(i));
      end
    end
    in_valid = 1'b0; out_ack = 1'b1;
    cycle();
    out_ack = 1'b0;
    checks++;
    if (loaded !== 8'h00 || ptr !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack: loaded=%h ptr=%0d ready=%b want 00 0 1", loaded, ptr, in_ready);
    end
    checks++;
    if (o0 !== 16'h1000 || o7 !== 16'h1007) begin
      errors++; $display("FAIL ack_retain: out0=%h out7=%h want 1000 1007", o0, o7);
    end
  endtask

  task automatic test_addressed();
    logic [2:0]  addr [3];
    logic [15:0] data [3];
    addr = '{3'd5, 3'd5, 3'd2};
    data = '{16'hAAAA, 16'hBBBB, 16'h1234};
    auto_m = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_addr(addr[i]); in0 = data[i];
      cycle();
      checks++;
      if (frame_done !== 1'b0 || ptr !== 3'd0) begin
        errors++; $display("FAIL addr_step%0d: done=%b ptr=%0d want 0 0", i, frame_done, ptr);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (o5 !== 16'hBBBB || o2 !== 16'h1234) begin
      errors++; $display("FAIL addr_data: out5=%h out2=%h want bbbb 1234", o5, o2);
    end
    checks++;
    if (loaded !== 8'b0010_0100) begin
      errors++; $display("FAIL addr_loaded: got %b want 00100100", loaded);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (loaded !== 8'h00 || ptr !== 3'd0 || o5 !== 16'hBBBB) begin
      errors++;
      $display("FAIL addr_clear: loaded=%h ptr=%0d out5=%h want 00 0 bbbb", loaded, ptr, o5);
    end
  endtask

  task automatic test_mixed();
    in_valid = 1'b1; auto_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0 = 16'h2000 + 16'(i);
      cycle();
    end
    checks++;
    if (ptr !== 3'd3 || loaded !== 8'h07) begin
      errors++; $display("FAIL mixed_auto: ptr=%0d loaded=%h want 3 07", ptr, loaded);
    end
    auto_m = 1'b0;
    for (int i = 3; i < 7; i++) begin
      set_addr(3'(i)); in0 = 16'h2100 + 16'(i);
      cycle();
    end
    checks++;
    if (ptr !== 3'd3 || loaded !== 8'h7F) begin
      errors++; $display("FAIL mixed_addr: ptr=%0d loaded=%h want 3 7f", ptr, loaded);
    end
    auto_m = 1'b1; set_addr(3'd7); in0 = 16'h2200;
    cycle();
    checks++;
    if (ptr !== 3'd4 || o3 !== 16'h2200 || loaded !== 8'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mixed_overwrite: ptr=%0d out3=%h loaded=%h done=%b want 4 2200 7f 0",
               ptr, o3, loaded, frame_done);
    end
    auto_m = 1'b0; set_addr(3'd7); in0 = 16'h2107;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || loaded !== 8'hFF || o7 !== 16'h2107 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mixed_complete: done=%b loaded=%h out7=%h ready=%b want 1 ff 2107 0",
               frame_done, loaded, o7, in_ready);
    end
    checks++;
    if (o0 !== 16'h2000 || o2 !== 16'h2002 || o6 !== 16'h2106) begin
      errors++; $display("FAIL mixed_data: out0=%h out2=%h out6=%h want 2000 2002 2106", o0, o2, o6);
    end
    out_ack = 1'b1;
    cycle();
    out_ack = 1'b0;
  endtask

  task automatic test_clear();
    auto_m = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in0 = 16'h3000 + 16'(i);
      cycle();
    end
    clear = 1'b1; in0 = 16'h5555;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL clear_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (loaded !== 8'h00 || ptr !== 3'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL clear_ctrl: loaded=%h ptr=%0d done=%b want 00 0 0", loaded, ptr, frame_done);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs[i] !== 16'h3000 + 16'(i)) begin
        errors++; $display("FAIL clear_out%0d: got %h want %h", i, outs[i], 16'h3000 + 16'(i));
      end
    end
    checks++;
    if (o4 !== 16'h2104) begin
      errors++; $display("FAIL clear_no_accept: out4=%h want 2104", o4);
    end
  endtask

  task automatic test_async_reset();
    auto_m = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in0 = 16'h4000 + 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o0 !== 16'h0 || o1 !== 16'h0 || o7 !== 16'h0 || loaded !== 8'h00 || ptr !== 3'd0
        || in_ready !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out0=%h out1=%h out7=%h loaded=%h ptr=%0d ready=%b want all 0",
               o0, o1, o7, loaded, ptr, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in0 = 16'h4444;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (o0 !== 16'h4444 || ptr !== 3'd1 || loaded !== 8'h01) begin
      errors++; $display("FAIL async_resume: out0=%h ptr=%0d loaded=%h want 4444 1 01", o0, ptr, loaded);
    end
  endtask

  initial begin
    test_reset();
    test_auto_fill();
    test_full_hold();
    test_addressed();
    test_mixed();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
